seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles each digit stays lit (valid range 2..2^20).
REQ-002 SHALL have parameter HEX_MODE, default 0; 0 = signed decimal display, 1 = hex display of value[15:0].
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port value  input  32  two's-complement word to display (CPU register x5 contents).
REQ-006 SHALL have port load  input  1  one-cycle strobe that samples value.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port segments  output  8  active-low cathodes, bit7 = dp, bits6..0 = g..a.
REQ-009 SHALL have port an  output  4  active-low one-hot anodes, an[0] = rightmost digit.

Function
REQ-010 SHALL implement FSM states IDLE, CONV, LATCH; busy = 1 in CONV and LATCH only.
REQ-011 SHALL, on load in IDLE at edge N, capture value, enter CONV at N+1, hold CONV 14 cycles, LATCH 1 cycle, return to IDLE; busy high for exactly 15 cycles.
REQ-012 SHALL update all four digit registers simultaneously on the LATCH cycle; the new image is visible from cycle N+16 and never partially.
REQ-013 SHALL, in decimal mode, convert the magnitude (lower 14 bits after range check) with sequential shift-add-3, one bit per CONV cycle.
REQ-014 SHALL display 0..9999 right-aligned with leading-zero blanking; value 0 shows a single "0" on an[0].
REQ-015 SHALL display -1..-999 with the minus sign in the digit immediately left of the most significant nonzero digit, blanks further left.
REQ-016 SHALL display "----" on all digits for value > 9999 or value < -999 (overflow).
REQ-017 SHALL, in hex mode, show value[15:0] as four hex digits, no blanking, no sign, same 15-cycle busy timing.
REQ-018 SHALL use encodings (dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E, minus BF, blank FF.
REQ-019 SHALL keep dp (segments[7]) = 1 at all times.
REQ-020 SHALL count a refresh counter 0..REFRESH_DIV-1; on wrap the scan index advances 0->1->2->3->0; an = ~(1 << index).
REQ-021 SHALL drive segments from the digit register selected by the scan index in the same cycle as an (no one-cycle skew).
REQ-022 SHALL, on load while busy, store value into a single pending register (later loads overwrite earlier ones) and start its conversion the cycle after LATCH.
REQ-023 SHALL, on load in the same cycle as LATCH, treat it as pending per REQ-022.
REQ-024 SHALL keep the scan running and the old image displayed during conversion.

Reset
REQ-025 SHALL, while rst = 1, force state IDLE, busy = 0, pending cleared, refresh counter 0, scan index 0, an = 1110, all digit registers blank (segments = FF).
REQ-026 SHALL give rst priority over load; load sampled in a rst cycle is discarded.
REQ-027 SHALL, on rst asserted mid-CONV or LATCH, abort the conversion and leave no partial digits.

Verification (REFRESH_DIV = 4 unless noted)
REQ-028 SHALL cover: rst 1 cycle -> an = 1110, segments = FF, busy = 0; scan stepping every 4 cycles: an 1110->1101->1011->0111->1110.
REQ-029 SHALL cover: load value = 1234 -> busy high 15 cycles; then an 1110:99, 1101:B0, 1011:A4, 0111:F9.
REQ-030 SHALL cover: load value = -42 -> an 1110:A4, 1101:99, 1011:BF, 0111:FF; load 0 -> an 1110:C0, others FF.
REQ-031 SHALL cover: load 10000 and load -1000 -> all four digits BF; load 9999 -> 90 on all four digits.
REQ-032 SHALL cover: HEX_MODE = 1, load 32'h1234BEEF -> an 0111:83, 1011:86, 1101:86, 1110:8E.
REQ-033 SHALL cover: load 5, load 6 at +3, load 7 at +5 -> shows 5, then 7 (6 never displayed), busy continuous 30 cycles; rst at +8 of a conversion -> blank, busy = 0 next cycle.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seg7_scan_driver                                           |
// | Brief   : 4-digit multiplexed 7-segment driver. Converts a 32-bit    |
// |           signed word to decimal (or hex) and scans it onto an       |
// |           active-low common-anode display.                           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_MODE    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  output logic        busy,
  output logic [7:0]  segments,
  output logic [3:0]  an
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  localparam logic [19:0] C_REF_MAX   = 20'(REFRESH_DIV - 1);
  localparam logic [3:0]  C_CONV_LAST = 4'd13;
  localparam logic [7:0]  C_MINUS     = 8'hBF;
  localparam logic [7:0]  C_BLANK     = 8'hFF;

  // Hex nibble to active-low segment code, dp off.
  function automatic logic [7:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] sh_q, sh_d;
  logic [15:0] bcd_q, bcd_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;
  logic        pv_q, pv_d;
  logic [31:0] pend_q, pend_d;
  logic [7:0]  seg_q [4];
  logic [7:0]  seg_d [4];
  logic [19:0] ref_q;
  logic [1:0]  idx_q;

  logic [31:0] src;
  logic        src_neg;
  logic [31:0] src_mag;
  logic        src_ovf;
  logic [15:0] adj;
  logic [7:0]  img [4];
  int          msd;

  // Pick the word to convert (pending word wins at LATCH unless a fresh load overrides it) and range-check it.
  always_comb begin
    src     = (state_q == S_LATCH && !load) ? pend_q : value;
    src_neg = src[31];
    src_mag = src_neg ? (~src + 32'd1) : src;
    src_ovf = src_neg ? (src_mag > 32'd999) : (src_mag > 32'd9999);
  end

  // Add-3 correction on every BCD nibble ahead of the next shift.
  always_comb begin
    adj = '0;
    for (int k = 0; k < 4; k++) begin
      adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
  end

  // Build the display image from the finished conversion: blanking, sign placement, overflow dashes.
  always_comb begin
    msd = 0;
    if (bcd_q[15:12] != 4'd0)     msd = 3;
    else if (bcd_q[11:8] != 4'd0) msd = 2;
    else if (bcd_q[7:4] != 4'd0)  msd = 1;
    for (int i = 0; i < 4; i++) begin
      img[i] = hex7(bcd_q[4*i +: 4]);
      if (HEX_MODE == 0) begin
        if (ovf_q)        img[i] = C_MINUS;
        else if (i > msd) img[i] = (neg_q && i == msd + 1) ? C_MINUS : C_BLANK;
      end
    end
  end

  // Conversion FSM next-state and datapath.
  always_comb begin
    logic start;
    start   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    pv_d    = pv_q;
    pend_d  = pend_q;
    for (int i = 0; i < 4; i++) seg_d[i] = seg_q[i];

    case (state_q)
      S_IDLE: begin
        if (load) start = 1'b1;
      end
      S_CONV: begin
        if (HEX_MODE == 0) begin
          bcd_d = {adj[14:0], sh_q[13]};
          sh_d  = {sh_q[12:0], 1'b0};
        end
        if (load) begin
          pv_d   = 1'b1;
          pend_d = value;
        end
        if (cnt_q == C_CONV_LAST) state_d = S_LATCH;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      S_LATCH: begin
        for (int i = 0; i < 4; i++) seg_d[i] = img[i];
        pv_d = 1'b0;
        if (load || pv_q) start   = 1'b1;
        else              state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_CONV;
      cnt_d   = 4'd0;
      if (HEX_MODE != 0) begin
        bcd_d = src[15:0];
        sh_d  = '0;
        neg_d = 1'b0;
        ovf_d = 1'b0;
      end else begin
        bcd_d = '0;
        sh_d  = src_mag[13:0];
        neg_d = src_neg;
        ovf_d = src_ovf;
      end
    end
  end

  // Conversion state registers; reset aborts any conversion and blanks the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pv_q    <= 1'b0;
      pend_q  <= '0;
      seg_q   <= '{default: C_BLANK};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      pv_q    <= pv_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
    end
  end

  // Refresh divider and scan index; runs independently of conversions.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
    end else if (ref_q == C_REF_MAX) begin
      ref_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      ref_q <= ref_q + 20'd1;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign an       = ~(4'b0001 << idx_q);
  assign segments = {1'b1, seg_q[idx_q][6:0]};

endmodule
`default_nettype wire
